alu_noc_port_arbiter: RTL and testbench
=======================================

// Module: alu_noc_port_arbiter
// PURPOSE
//  Output-link arbiter for one direction (N/E/S/W) of an ALU NoC tile. Shares the
//  single outgoing {a,b,ctrl,valid} link between NUM_REQ requesters (0=N,1=E,2=S,
//  3=W,4=host) using round-robin. One registered output stage with valid/ready
//  handshake, sustaining one packet per cycle.
// PARAMETERS
//  DATA_W   64  width of each operand field (a, b)
//  CTRL_W   16  width of ctrl field
//  NUM_REQ  5   number of requesters; index 0..NUM_REQ-1
//  CNT_W    16  width of per-requester grant counters (ARB_PERF_CNT_EN only)
// PORTS
//  clk         in   1               clock, all state on rising edge
//  rst         in   1               asynchronous, active-high reset
//  req_valid   in   NUM_REQ         requester i has a packet
//  req_a       in   NUM_REQ*DATA_W  operand a, slice i = [i*DATA_W +: DATA_W]
//  req_b       in   NUM_REQ*DATA_W  operand b, same slicing
//  req_ctrl    in   NUM_REQ*CTRL_W  ctrl, slice i = [i*CTRL_W +: CTRL_W]
//  req_ready   out  NUM_REQ         one-hot grant; packet i accepted when valid&ready
//  out_valid   out  1               output register holds a packet
//  out_a       out  DATA_W          registered operand a
//  out_b       out  DATA_W          registered operand b
//  out_ctrl    out  CTRL_W          registered ctrl
//  out_src     out  3               index of requester that supplied the packet
//  out_ready   in   1               downstream link accepts packet this cycle
//  grant_cnt   out  NUM_REQ*CNT_W   per-requester accepted count (ARB_PERF_CNT_EN only)
// BEHAVIOUR
//  - Reset: out_valid=0, out_a/out_b/out_ctrl=0, out_src=0, rr_ptr=0 (req 0 first),
//    grant_cnt=0. In-flight packet in output register is discarded on reset.
//  - can_load = !out_valid | out_ready (register empty or draining this cycle).
//  - req_ready: combinational, at most one bit set, only when can_load. Winner is
//    first i with req_valid[i] searching rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ.
//  - req_ready[i] may depend on req_valid (no ready-before-valid requirement);
//    requesters must hold valid and data stable until accepted.
//  - Accept (req_valid[i]&req_ready[i]): next edge loads out_* from slice i,
//    out_src=i, out_valid=1; rr_ptr <= (i+1) mod NUM_REQ. Latency 1 cycle.
//  - Drain without accept: out_valid&out_ready and no request -> out_valid<=0;
//    out_a/b/ctrl/src hold last value.
//  - Stall: out_valid&!out_ready -> all out_* hold stable, req_ready=0, rr_ptr holds.
//  - Simultaneous drain+accept: new packet loaded, out_valid stays 1 (no bubble).
//  - No requests: rr_ptr unchanged. Single persistent requester gets every cycle.
//  - Fairness: with all NUM_REQ requesting continuously and out_ready=1, each
//    requester is granted exactly once per NUM_REQ consecutive grants.
//  - Widths: rr_ptr is $clog2(NUM_REQ) bits; wrap from NUM_REQ-1 to 0 explicit
//    (not power-of-two wrap).
// CONFIGURATION
//  ARB_PERF_CNT_EN defined: grant_cnt port present; slice i increments by 1 on each
//    accept of requester i, saturates at 2^CNT_W-1 (no wrap), cleared only by rst.
//  ARB_PERF_CNT_EN undefined: grant_cnt port and counters absent; arbitration and
//    handshake behaviour identical.
// TESTING
//  T1 reset: assert rst mid-stall with out_valid=1 -> out_valid=0, req_ready=0
//     while no req, next grant goes to req 0 after release.
//  T2 single: req 2 valid, a=64'h1, b=64'h2, ctrl=16'h00A5, out_ready=1 ->
//     req_ready=5'b00100 same cycle; next cycle out_valid=1, out_src=2, out_a=1.
//  T3 round-robin: all 5 valid continuously, out_ready=1 -> out_src sequence
//     0,1,2,3,4,0,1 on consecutive cycles, out_valid never drops.
//  T4 backpressure: out_valid=1, out_ready=0 for 4 cycles with req 1,3 valid ->
//     out_* stable, req_ready=0; on out_ready=1 req 1 (nearest from rr_ptr) granted.
//  T5 skip/wrap: rr_ptr=4 after grant to 3, only req 1 valid -> req 1 granted,
//     rr_ptr becomes 2; then only req 0 valid -> granted (wrap through 4).
//  T6 ARB_PERF_CNT_EN, CNT_W=4: 20 accepts from req 4 -> grant_cnt[4] = 15
//     (saturated), other slices 0.

Source files
------------

// File: rtl/alu_noc_port_arbiter.sv
// Round-robin output-link arbiter for one NoC tile direction with a single registered output stage.
// Optional per-requester saturating grant counters are enabled with `define ARB_PERF_CNT_EN.
module alu_noc_port_arbiter #(
    parameter int DATA_W  = 64,
    parameter int CTRL_W  = 16,
    parameter int NUM_REQ = 5
`ifdef ARB_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_a,
    output logic [DATA_W-1:0]         out_b,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [2:0]                out_src,
    input  logic                      out_ready
`ifdef ARB_PERF_CNT_EN
    , output logic [NUM_REQ*CNT_W-1:0] grant_cnt
`endif
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0][DATA_W-1:0] a_arr, b_arr;
    logic [NUM_REQ-1:0][CTRL_W-1:0] ctrl_arr;
    logic [PTR_W-1:0]               rr_ptr;
    logic [PTR_W-1:0]               grant_idx;
    logic                           found;
    logic                           can_load;
    logic                           accept;

    assign a_arr    = req_a;
    assign b_arr    = req_b;
    assign ctrl_arr = req_ctrl;

    assign can_load = !out_valid || out_ready;
    assign accept   = can_load && found;

    // Scan rr_ptr, rr_ptr+1, ... with an explicit mod-NUM_REQ wrap.
    always_comb begin
        int idx;
        idx       = 0;
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_ctrl  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_a     <= a_arr[grant_idx];
            out_b     <= b_arr[grant_idx];
            out_ctrl  <= ctrl_arr[grant_idx];
            out_src   <= 3'(grant_idx);
            rr_ptr    <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (out_ready) begin
            // Drain with nothing to load: payload fields keep their last value.
            out_valid <= 1'b0;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && (cnt_q[i] != {CNT_W{1'b1}}))
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_alu_noc_port_arbiter.sv
// Bench for alu_noc_port_arbiter: directed vector table, reset corner case, and a
// randomized phase checked against a rotating-priority-queue reference model.
module tb_alu_noc_port_arbiter;
    localparam int N  = 5;
    localparam int DW = 64;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_a = '0;
    logic [N*DW-1:0]   req_b = '0;
    logic [N*CW-1:0]   req_ctrl = '0;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_a, out_b;
    logic [CW-1:0]     out_ctrl;
    logic [2:0]        out_src;
    logic              out_ready = 1'b0;
`ifdef ARB_PERF_CNT_EN
    logic [N*4-1:0]    grant_cnt;
`endif

    alu_noc_port_arbiter #(
        .DATA_W(DW), .CTRL_W(CW), .NUM_REQ(N)
`ifdef ARB_PERF_CNT_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ctrl(req_ctrl), .req_ready(req_ready), .out_valid(out_valid),
        .out_a(out_a), .out_b(out_b), .out_ctrl(out_ctrl), .out_src(out_src),
        .out_ready(out_ready)
`ifdef ARB_PERF_CNT_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int tag   = 0;
    logic [DW-1:0] ea = '0, eb = '0;
    logic [CW-1:0] ec = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Directed step: expectations are constants supplied by the caller.
    task automatic apply(input logic [N-1:0] v, input logic ordy, input logic [N-1:0] erdy,
                         input logic eov, input logic [2:0] esrc, input string nm);
        tag++;
        req_valid = v;
        out_ready = ordy;
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW]    = {32'(tag), 32'(i)};
            req_b[i*DW +: DW]    = ~{32'(tag), 32'(i)};
            req_ctrl[i*CW +: CW] = 16'(tag * 8 + i);
        end
        @(negedge clk);
        chk({nm, " req_ready"}, 64'(req_ready), 64'(erdy));
        for (int i = 0; i < N; i++) begin
            if (erdy[i]) begin
                ea = {32'(tag), 32'(i)};
                eb = ~{32'(tag), 32'(i)};
                ec = 16'(tag * 8 + i);
            end
        end
        @(posedge clk); #1;
        chk({nm, " out_valid"}, 64'(out_valid), 64'(eov));
        chk({nm, " out_src"}, 64'(out_src), 64'(esrc));
        chk({nm, " out_a"}, out_a, ea);
        chk({nm, " out_b"}, out_b, eb);
        chk({nm, " out_ctrl"}, 64'(out_ctrl), 64'(ec));
    endtask

    typedef struct {
        logic [N-1:0] v;
        logic         ordy;
        logic [N-1:0] rdy;
        logic         ov;
        logic [2:0]   src;
    } vec_t;
    vec_t tbl[22];

    // Reference model: priority order kept as a queue, the granted requester moves to the back.
    int            q[$];
    logic          m_ov;
    logic [DW-1:0] m_a, m_b;
    logic [CW-1:0] m_c;
    logic [2:0]    m_src;
    int            m_cnt[N];
    logic [N-1:0]  pend;
    logic [DW-1:0] pa[N], pb[N];
    logic [CW-1:0] pc[N];

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < N; i++) begin
            q.push_back(i);
            m_cnt[i] = 0;
        end
        m_ov = 1'b0; m_a = '0; m_b = '0; m_c = '0; m_src = '0;
        pend = '0;
    endtask

    task automatic hw_reset();
        req_valid = '0;
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        ea = '0; eb = '0; ec = '0;
    endtask

    task automatic rand_cycle(input int n);
        logic         ordy;
        logic [N-1:0] erdy;
        int           w;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom % 3 != 0)) begin
                pend[i] = 1'b1;
                pa[i] = {$urandom, $urandom};
                pb[i] = {$urandom, $urandom};
                pc[i] = 16'($urandom);
            end
            if (pend[i]) begin
                req_a[i*DW +: DW]    = pa[i];
                req_b[i*DW +: DW]    = pb[i];
                req_ctrl[i*CW +: CW] = pc[i];
            end else begin
                req_a[i*DW +: DW]    = {$urandom, $urandom};
                req_b[i*DW +: DW]    = {$urandom, $urandom};
                req_ctrl[i*CW +: CW] = 16'($urandom);
            end
        end
        ordy = ($urandom % 4) != 0;
        req_valid = pend;
        out_ready = ordy;
        w = -1;
        erdy = '0;
        if (!m_ov || ordy) begin
            foreach (q[k]) if (w < 0 && pend[q[k]]) w = q[k];
        end
        if (w >= 0) erdy[w] = 1'b1;
        @(negedge clk);
        chk($sformatf("rand%0d req_ready", n), 64'(req_ready), 64'(erdy));
        if (w >= 0) begin
            m_ov = 1'b1; m_a = pa[w]; m_b = pb[w]; m_c = pc[w]; m_src = 3'(w);
            if (m_cnt[w] < 15) m_cnt[w]++;
            pend[w] = 1'b0;
            while (q[0] != w) q.push_back(q.pop_front());
            q.push_back(q.pop_front());
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        @(posedge clk); #1;
        chk($sformatf("rand%0d out_valid", n), 64'(out_valid), 64'(m_ov));
        chk($sformatf("rand%0d out_src", n), 64'(out_src), 64'(m_src));
        chk($sformatf("rand%0d out_a", n), out_a, m_a);
        chk($sformatf("rand%0d out_b", n), out_b, m_b);
        chk($sformatf("rand%0d out_ctrl", n), 64'(out_ctrl), 64'(m_c));
    endtask

    initial begin
        // round-robin, single request, drain, backpressure, skip/wrap, idle load
        tbl[0]  = '{5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0};
        tbl[1]  = '{5'b11111, 1'b1, 5'b00010, 1'b1, 3'd1};
        tbl[2]  = '{5'b11111, 1'b1, 5'b00100, 1'b1, 3'd2};
        tbl[3]  = '{5'b11111, 1'b1, 5'b01000, 1'b1, 3'd3};
        tbl[4]  = '{5'b11111, 1'b1, 5'b10000, 1'b1, 3'd4};
        tbl[5]  = '{5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0};
        tbl[6]  = '{5'b11111, 1'b1, 5'b00010, 1'b1, 3'd1};
        tbl[7]  = '{5'b00100, 1'b1, 5'b00100, 1'b1, 3'd2};
        tbl[8]  = '{5'b00000, 1'b1, 5'b00000, 1'b0, 3'd2};
        tbl[9]  = '{5'b01010, 1'b1, 5'b01000, 1'b1, 3'd3};
        tbl[10] = '{5'b01010, 1'b0, 5'b00000, 1'b1, 3'd3};
        tbl[11] = '{5'b01010, 1'b0, 5'b00000, 1'b1, 3'd3};
        tbl[12] = '{5'b01010, 1'b0, 5'b00000, 1'b1, 3'd3};
        tbl[13] = '{5'b01010, 1'b0, 5'b00000, 1'b1, 3'd3};
        tbl[14] = '{5'b01010, 1'b1, 5'b00010, 1'b1, 3'd1};
        tbl[15] = '{5'b01000, 1'b1, 5'b01000, 1'b1, 3'd3};
        tbl[16] = '{5'b00010, 1'b1, 5'b00010, 1'b1, 3'd1};
        tbl[17] = '{5'b00001, 1'b1, 5'b00001, 1'b1, 3'd0};
        tbl[18] = '{5'b00000, 1'b0, 5'b00000, 1'b1, 3'd0};
        tbl[19] = '{5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0};
        tbl[20] = '{5'b00000, 1'b0, 5'b00000, 1'b0, 3'd0};
        tbl[21] = '{5'b10000, 1'b0, 5'b10000, 1'b1, 3'd4};

        @(posedge clk); #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_src", 64'(out_src), 64'd0);
        chk("reset out_a", out_a, 64'd0);
        chk("reset req_ready", 64'(req_ready), 64'd0);
`ifdef ARB_PERF_CNT_EN
        chk("reset grant_cnt", 64'(grant_cnt), 64'd0);
`endif
        rst = 1'b0;

        for (int r = 0; r < 22; r++)
            apply(tbl[r].v, tbl[r].ordy, tbl[r].rdy, tbl[r].ov, tbl[r].src, $sformatf("vec%0d", r));

        // Reset arriving while the output register is stalled with a packet.
        req_valid = 5'b01000;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t1 stall req_ready", 64'(req_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("t1 rst out_valid", 64'(out_valid), 64'd0);
        chk("t1 rst out_src", 64'(out_src), 64'd0);
        chk("t1 rst out_a", out_a, 64'd0);
        req_valid = '0;
        #1;
        chk("t1 rst req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ea = '0; eb = '0; ec = '0;
        apply(5'b11111, 1'b0, 5'b00001, 1'b1, 3'd0, "t1 first grant");

        hw_reset();
        for (int n = 0; n < 400; n++) rand_cycle(n);
`ifdef ARB_PERF_CNT_EN
        for (int i = 0; i < N; i++)
            chk($sformatf("rand grant_cnt[%0d]", i), 64'(grant_cnt[i*4 +: 4]), 64'(m_cnt[i]));

        hw_reset();
        req_valid = 5'b10000;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            chk($sformatf("t6 grant_cnt[%0d]", i), 64'(grant_cnt[i*4 +: 4]), (i == 4) ? 64'd15 : 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
